// File: rtl/rsa_encoder.sv
// Fixed-key RSA encryption core: data_out = data_in^e mod n.
// Left-to-right square-and-multiply over a bit-serial radix-2 Montgomery
// multiplier. Each MonPro takes k iterations plus one final-subtract cycle.
// The load of the next product overlaps that final cycle. Only the very
// first product spends a separate load cycle, after x has been captured.
module rsa_encoder #(
   parameter int unsigned n      = 3551,
   parameter int unsigned e      = 5,
   parameter int unsigned k      = 12,
   parameter int unsigned logk   = 4,
   parameter int unsigned exp_2k = 2292
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [k-1:0] data_in,
   output logic [k-1:0] data_out,
   output logic         done
);
   localparam int unsigned   CW       = logk + 1;
   localparam logic [k-1:0]  E_K      = k'(e);
   localparam logic [k-1:0]  R2_K     = k'(exp_2k);
   localparam logic [k+1:0]  N_S      = (k+2)'(n);
   localparam logic [CW-1:0] CNT_LAST = CW'(k + 1);

   typedef enum logic [2:0] {IDLE, PRE_X, PRE_A, EXP_SQ, EXP_MUL, POST, DONE} state_t;

   state_t         state_q, state_d;
   logic [k-1:0]   x_q, x_d;
   logic [k-1:0]   xm_q, xm_d;
   logic [k-1:0]   op_a_q, op_a_d;    // MonPro multiplier, shifted right each iteration
   logic [k-1:0]   op_b_q, op_b_d;    // MonPro multiplicand
   logic [k+1:0]   s_q, s_d;          // MonPro accumulator, always < 2n
   logic [CW-1:0]  cnt_q, cnt_d;      // 0 = load, 1..k = iterate, k+1 = final
   logic [logk-1:0] i_q, i_d;         // exponent bit index
   logic [k-1:0]   data_out_q, data_out_d;
   logic           done_q, done_d;

   logic [k+1:0]   t_add, t_odd;
   logic [k-1:0]   mp_res;

   // One Montgomery iteration and the final conditional subtraction.
   always_comb begin
      t_add  = s_q + (op_a_q[0] ? {2'b00, op_b_q} : '0);
      t_odd  = t_add[0] ? t_add + N_S : t_add;
      mp_res = (s_q >= N_S) ? k'(s_q - N_S) : k'(s_q);
   end

   // Sequencer: the running A lives in op_a/op_b, reloaded from mp_res.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      xm_d       = xm_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      s_d        = s_q;
      cnt_d      = cnt_q;
      i_d        = i_q;
      data_out_d = data_out_q;
      done_d     = done_q;
      case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (start) begin
               x_d     = data_in;
               cnt_d   = '0;
               state_d = PRE_X;
            end
         end
         DONE: begin
            if (!start) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            if (cnt_q == '0) begin
               s_d    = '0;
               op_a_d = x_q;
               op_b_d = R2_K;
               cnt_d  = CW'(1);
            end else if (cnt_q != CNT_LAST) begin
               s_d    = t_odd >> 1;
               op_a_d = op_a_q >> 1;
               cnt_d  = cnt_q + CW'(1);
            end else begin
               s_d   = '0;
               cnt_d = CW'(1);
               case (state_q)
                  PRE_X: begin
                     xm_d    = mp_res;
                     op_a_d  = k'(1);
                     op_b_d  = R2_K;
                     state_d = PRE_A;
                  end
                  PRE_A: begin
                     i_d     = logk'(k - 1);
                     op_a_d  = mp_res;
                     op_b_d  = mp_res;
                     state_d = EXP_SQ;
                  end
                  EXP_SQ: begin
                     op_a_d = mp_res;
                     if (E_K[i_q]) begin
                        op_b_d  = xm_q;
                        state_d = EXP_MUL;
                     end else if (i_q == '0) begin
                        op_b_d  = k'(1);
                        state_d = POST;
                     end else begin
                        op_b_d = mp_res;
                        i_d    = i_q - logk'(1);
                     end
                  end
                  EXP_MUL: begin
                     op_a_d = mp_res;
                     if (i_q == '0) begin
                        op_b_d  = k'(1);
                        state_d = POST;
                     end else begin
                        op_b_d  = mp_res;
                        i_d     = i_q - logk'(1);
                        state_d = EXP_SQ;
                     end
                  end
                  POST: begin
                     data_out_d = mp_res;
                     done_d     = 1'b1;
                     state_d    = DONE;
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // State registers; rst_n is active-high and synchronous.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q    <= IDLE;
         x_q        <= '0;
         xm_q       <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         s_q        <= '0;
         cnt_q      <= '0;
         i_q        <= '0;
         data_out_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         xm_q       <= xm_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         s_q        <= s_d;
         cnt_q      <= cnt_d;
         i_q        <= i_d;
         data_out_q <= data_out_d;
         done_q     <= done_d;
      end
   end

   assign data_out = data_out_q;
   assign done     = done_q;

endmodule

// File: tb/tb_rsa_encoder.sv
// Directed bench for rsa_encoder: default key (e=5) and an e=1 instance
// driven by the same start/data_in, each checked for result and latency.
module tb_rsa_encoder;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [11:0] data_in;
   logic [11:0] data_out, data_out1;
   logic        done, done1;

   int n_pass  = 0;
   int n_total = 0;

   rsa_encoder u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .data_in(data_in), .data_out(data_out), .done(done)
   );

   rsa_encoder #(.e(1)) u_dut_e1 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .data_in(data_in), .data_out(data_out1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   // One full transaction; optional mid-run toggle of start/data_in.
   task automatic run(input string tag, input logic [11:0] din,
                      input logic [11:0] expv, input int toggle_at);
      int lat0, lat1;
      logic [11:0] exp1;
      exp1 = 12'(32'(din) % 3551);
      lat0 = -1;
      lat1 = -1;
      @(negedge clk);
      data_in = din;
      start   = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk);
         #1;
         if (done  && lat0 < 0) lat0 = c;
         if (done1 && lat1 < 0) lat1 = c;
         if (toggle_at > 0 && c == toggle_at) begin
            start   = 1'b0;
            data_in = ~din;
         end
         if (toggle_at > 0 && c == toggle_at + 5) start = 1'b1;
         if (lat0 >= 0 && lat1 >= 0) break;
      end
      chk({tag, " lat"},     lat0,      222);
      chk({tag, " data"},    data_out,  expv);
      chk({tag, " e1 lat"},  lat1,      209);
      chk({tag, " e1 data"}, data_out1, exp1);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, " hold done"}, done,     1);
      chk({tag, " hold data"}, data_out, expv);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " drop done"},    done,     0);
      chk({tag, " drop e1 done"}, done1,    0);
      chk({tag, " keep data"},    data_out, expv);
   endtask

   initial begin
      rst_n   = 1'b1;
      start   = 1'b0;
      data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst done",     done,      0);
      chk("rst data",     data_out,  0);
      chk("rst e1 done",  done1,     0);
      chk("rst e1 data",  data_out1, 0);
      @(negedge clk);
      rst_n = 1'b0;

      run("1234",   12'd1234, 12'd2959, 0);
      run("2",      12'd2,    12'd32,   0);
      run("1",      12'd1,    12'd1,    0);
      run("0",      12'd0,    12'd0,    0);
      run("n-1",    12'd3550, 12'd3550, 0);
      run("n+1",    12'd3552, 12'd1,    0);
      run("toggle", 12'd1234, 12'd2959, 60);

      // Reset mid-computation aborts and clears outputs.
      @(negedge clk);
      data_in = 12'd777;
      start   = 1'b1;
      @(posedge clk);
      repeat (50) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst done",    done,      0);
      chk("midrst data",    data_out,  0);
      chk("midrst e1 done", done1,     0);
      chk("midrst e1 data", data_out1, 0);
      @(negedge clk);
      rst_n = 1'b0;

      run("after rst", 12'd1234, 12'd2959, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
